pkt_bus_to_bytes: RTL

PKT_BUS_TO_BYTES -- requirements
Module: pkt_bus_to_bytes

---
 rtl/pkt_bus_to_bytes.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pkt_bus_to_bytes.sv
// ---------------------------------------------------------------------------
// pkt_bus_to_bytes
// Converts a 10-byte-wide packet bus (no backpressure) into a byte stream with
// valid/ready handshake. Input words are buffered in a word FIFO; words that
// arrive while the FIFO is full are dropped and the affected packet is closed
// with a one-byte abort terminator (m_last=1, m_err=1).
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   bus_state  : valid packet word on bus_data this cycle
//   bus_stop   : with bus_state, final word of the packet
//   bus_data   : 10 bytes, byte k = bus_data[8k+7:8k], byte 0 first
//   m_data     : output byte
//   m_valid    : qualifies m_data / m_last / m_err
//   m_ready    : sink accepts byte when high with m_valid
//   m_last     : final byte of a packet
//   m_err      : abort terminator byte (only together with m_last)
//   pkt_done   : one-cycle pulse after each m_last transfer
//   pkt_len    : byte count of the completed packet, valid with pkt_done
//   overflow   : sticky, set on any dropped input word
//   drop_cnt   : dropped input word count, saturating
// ---------------------------------------------------------------------------
module pkt_bus_to_bytes #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_state,
   input  logic        bus_stop,
   input  logic [79:0] bus_data,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        m_err,
   output logic        pkt_done,
   output logic [15:0] pkt_len,
   output logic        overflow,
   output logic [15:0] drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_PASS    = 2'd0;
   localparam logic [1:0] ST_DISCARD = 2'd1;
   localparam logic [1:0] ST_TERM    = 2'd2;

   // Word FIFO: {data[79:0], last}; the abort marker is kept alongside so that
   // a genuine all-zero last word can never be mistaken for a terminator.
   logic [80:0] mem_word  [FIFO_DEPTH];
   logic        mem_abort [FIFO_DEPTH];

   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty;

   // Full/empty from registered pointers only: a pop in the same cycle does
   // not free space for that cycle's write.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // ---------------------------------------------------------------- writer
   logic [1:0] state, state_nxt;
   logic       term_pend, term_pend_nxt;  // TERM: a new packet is in flight
   logic       wr_en, wr_abort, drop, in_pkt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      term_pend_nxt = term_pend;
      wr_en         = 1'b0;
      wr_abort      = 1'b0;
      drop          = 1'b0;
      in_pkt        = 1'b0;
      case (state)
         ST_PASS: begin
            if (bus_state) begin
               if (!full) begin
                  wr_en = 1'b1;
               end else begin
                  drop          = 1'b1;
                  term_pend_nxt = 1'b0;
                  state_nxt     = bus_stop ? ST_TERM : ST_DISCARD;
               end
            end
         end
         ST_DISCARD: begin
            if (bus_state) begin
               drop          = 1'b1;
               term_pend_nxt = 1'b0;
               if (bus_stop) state_nxt = ST_TERM;
            end
         end
         ST_TERM: begin
            // Words seen here belong to a later packet that has lost its head;
            // track whether that packet is still open when the abort goes in.
            in_pkt = bus_state ? !bus_stop : term_pend;
            drop   = bus_state;
            if (!full) begin
               wr_en         = 1'b1;
               wr_abort      = 1'b1;
               term_pend_nxt = 1'b0;
               state_nxt     = in_pkt ? ST_DISCARD : ST_PASS;
            end else begin
               term_pend_nxt = in_pkt;
            end
         end
         default: state_nxt = ST_PASS;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together on the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_PASS;
         term_pend <= 1'b0;
         wr_ptr    <= '0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         term_pend <= term_pend_nxt;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // NOTE: the storage array has no reset; emptiness is defined by the
   // pointers, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_word[wr_ptr[AW-1:0]]  <= wr_abort ? {80'h0, 1'b1} : {bus_data, bus_stop};
         mem_abort[wr_ptr[AW-1:0]] <= wr_abort;
      end
   end

   // ------------------------------------------------------------ serializer
   logic [80:0] cur_word;
   logic [79:0] cur_data;
   logic        cur_abort;
   logic [7:0]  cur_byte;
   logic [3:0]  byte_idx;
   logic        load, end_of_entry, pop, xfer;
   logic [15:0] byte_cnt;

   assign cur_word     = mem_word[rd_ptr[AW-1:0]];
   assign cur_abort    = mem_abort[rd_ptr[AW-1:0]];
   assign cur_data     = cur_word[80:1];
   assign cur_byte     = cur_data[{byte_idx, 3'b000} +: 8];

   // The output register refills whenever it is empty or being drained, which
   // gives one byte per cycle across entry boundaries.
   assign xfer         = m_valid && m_ready;
   assign load         = !empty && (!m_valid || m_ready);
   assign end_of_entry = cur_abort || (byte_idx == 4'd9);
   assign pop          = load && end_of_entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         byte_idx <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         m_err    <= 1'b0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (load) begin
            m_valid  <= 1'b1;
            m_data   <= cur_abort ? 8'h00 : cur_byte;
            m_last   <= cur_abort || (cur_word[0] && (byte_idx == 4'd9));
            m_err    <= cur_abort;
            byte_idx <= end_of_entry ? 4'd0 : byte_idx + 4'd1;
         end else if (xfer) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------ packet statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         pkt_len  <= '0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= xfer && m_last;
         if (xfer) begin
            if (m_last) begin
               pkt_len  <= (byte_cnt == 16'hFFFF) ? 16'hFFFF : byte_cnt + 16'd1;
               byte_cnt <= '0;
            end else if (byte_cnt != 16'hFFFF) begin
               byte_cnt <= byte_cnt + 16'd1;
            end
         end
      end
   end

endmodule
